// File: rtl/stopwatch_bcd.sv
// ---------------------------------------------------------------------------
// stopwatch_bcd
//   MM:SS stopwatch counting one-cycle Tick pulses (1 s enables from the
//   upstream countdown timer). Keeps a live BCD count plus a display copy
//   that can be frozen (lap) while the live count keeps running.
//
// Parameters
//   MaxMinutes : highest minutes value (0..99); range 00:00..MaxMinutes:59
//   HoldAtMax  : 0 = wrap to 00:00 after max (Wrap pulse)
//                1 = saturate at max and enter DONE
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   tick_i         one-cycle count enable
//   start_stop_i   one-cycle pulse, toggles run/pause
//   clear_i        one-cycle pulse, back to 00:00 / IDLE
//   lap_i          one-cycle pulse, toggles display freeze while running
//   sec_ones_o     displayed seconds ones (0..9)
//   sec_tens_o     displayed seconds tens (0..5)
//   min_ones_o     displayed minutes ones (0..9)
//   min_tens_o     displayed minutes tens (0..9)
//   running_o      high in RUN or LAP
//   frozen_o       high in LAP
//   done_o         high in DONE
//   wrap_o         one-cycle pulse on rollover max -> 00:00
// ---------------------------------------------------------------------------
module stopwatch_bcd #(
  parameter int MaxMinutes = 59,
  parameter bit HoldAtMax  = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       start_stop_i,
  input  logic       clear_i,
  input  logic       lap_i,
  output logic [3:0] sec_ones_o,
  output logic [3:0] sec_tens_o,
  output logic [3:0] min_ones_o,
  output logic [3:0] min_tens_o,
  output logic       running_o,
  output logic       frozen_o,
  output logic       done_o,
  output logic       wrap_o
);

  typedef enum logic [2:0] {IDLE, RUN, PAUSE, LAP, DONE} state_e;

  typedef struct packed {
    logic [3:0] m10;
    logic [3:0] m1;
    logic [3:0] s10;
    logic [3:0] s1;
  } bcd_t;

  localparam bcd_t MaxVal = {4'(MaxMinutes / 10), 4'(MaxMinutes % 10), 4'd5, 4'd9};

  state_e state_q, state_d;
  bcd_t   live_q, live_d, disp_q, disp_d, live_inc;
  logic   running_q, frozen_q, done_q, wrap_q, wrap_d;
  logic   count_en, at_max, hold_hit;

  // BCD cascade increment. Max detect stops the count before minutes tens
  // could exceed its range, so the m10 wrap is only a safety net.
  always_comb begin
    live_inc = live_q;
    if (live_q.s1 != 4'd9) begin
      live_inc.s1 = live_q.s1 + 4'd1;
    end else begin
      live_inc.s1 = 4'd0;
      if (live_q.s10 != 4'd5) begin
        live_inc.s10 = live_q.s10 + 4'd1;
      end else begin
        live_inc.s10 = 4'd0;
        if (live_q.m1 != 4'd9) begin
          live_inc.m1 = live_q.m1 + 4'd1;
        end else begin
          live_inc.m1  = 4'd0;
          live_inc.m10 = (live_q.m10 == 4'd9) ? 4'd0 : live_q.m10 + 4'd1;
        end
      end
    end
  end

  assign at_max   = (live_q == MaxVal);
  // Tick qualifies on the pre-transition state; Clear discards it.
  assign count_en = tick_i && !clear_i && (state_q == RUN || state_q == LAP);

  always_comb begin
    state_d  = state_q;
    live_d   = live_q;
    wrap_d   = 1'b0;
    hold_hit = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
      live_d  = '0;
    end else begin
      if (count_en) begin
        if (!at_max) begin
          live_d = live_inc;
        end else if (HoldAtMax) begin
          hold_hit = 1'b1;
          state_d  = DONE;
        end else begin
          live_d = '0;
          wrap_d = 1'b1;
        end
      end
      // Saturating into DONE outranks any control arriving in the same cycle.
      if (!hold_hit) begin
        if (start_stop_i) begin
          case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = PAUSE;
            PAUSE:   state_d = RUN;
            LAP:     state_d = PAUSE;
            default: state_d = state_q;
          endcase
        end else if (lap_i) begin
          case (state_q)
            RUN:     state_d = LAP;
            LAP:     state_d = RUN;
            default: state_d = state_q;
          endcase
        end
      end
    end
  end

  // Display follows the next live value so a Tick shows one cycle later;
  // it holds only while remaining in LAP (entry captures the live value).
  always_comb begin
    disp_d = live_d;
    if (state_d == LAP && state_q == LAP) disp_d = disp_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      live_q    <= '0;
      disp_q    <= '0;
      running_q <= 1'b0;
      frozen_q  <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      live_q    <= live_d;
      disp_q    <= disp_d;
      running_q <= (state_d == RUN) || (state_d == LAP);
      frozen_q  <= (state_d == LAP);
      done_q    <= (state_d == DONE);
      wrap_q    <= wrap_d;
    end
  end

  assign sec_ones_o = disp_q.s1;
  assign sec_tens_o = disp_q.s10;
  assign min_ones_o = disp_q.m1;
  assign min_tens_o = disp_q.m10;
  assign running_o  = running_q;
  assign frozen_o   = frozen_q;
  assign done_o     = done_q;
  assign wrap_o     = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
module tb_stopwatch_bcd;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0, ss = 1'b0, clr = 1'b0, lap = 1'b0;

  logic [3:0] a_s1, a_s10, a_m1, a_m10, b_s1, b_s10, b_m1, b_m10, c_s1, c_s10, c_m1, c_m10;
  logic a_run, a_frz, a_done, a_wrap;
  logic b_run, b_frz, b_done, b_wrap;
  logic c_run, c_frz, c_done, c_wrap;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // a: default 59 min wrap; b: 1 min wrap; c: 1 min hold
  stopwatch_bcd #(.MaxMinutes(59), .HoldAtMax(1'b0)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .start_stop_i(ss), .clear_i(clr), .lap_i(lap),
    .sec_ones_o(a_s1), .sec_tens_o(a_s10), .min_ones_o(a_m1), .min_tens_o(a_m10),
    .running_o(a_run), .frozen_o(a_frz), .done_o(a_done), .wrap_o(a_wrap));

  stopwatch_bcd #(.MaxMinutes(1), .HoldAtMax(1'b0)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .start_stop_i(ss), .clear_i(clr), .lap_i(lap),
    .sec_ones_o(b_s1), .sec_tens_o(b_s10), .min_ones_o(b_m1), .min_tens_o(b_m10),
    .running_o(b_run), .frozen_o(b_frz), .done_o(b_done), .wrap_o(b_wrap));

  stopwatch_bcd #(.MaxMinutes(1), .HoldAtMax(1'b1)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .start_stop_i(ss), .clear_i(clr), .lap_i(lap),
    .sec_ones_o(c_s1), .sec_tens_o(c_s10), .min_ones_o(c_m1), .min_tens_o(c_m10),
    .running_o(c_run), .frozen_o(c_frz), .done_o(c_done), .wrap_o(c_wrap));

  wire [15:0] a_disp = {a_m10, a_m1, a_s10, a_s1};
  wire [15:0] b_disp = {b_m10, b_m1, b_s10, b_s1};
  wire [15:0] c_disp = {c_m10, c_m1, c_s10, c_s1};

  // One clock of stimulus: drive at negedge, return at next negedge
  // (the rising edge in between has registered the result).
  task automatic step(input logic t, input logic s, input logic c, input logic l);
    @(negedge clk);
    tick = t; ss = s; clr = c; lap = l;
    @(negedge clk);
    tick = 1'b0; ss = 1'b0; clr = 1'b0; lap = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    #23;
    n_chk++;
    if (a_disp !== 16'h0000 || a_run !== 1'b0 || a_frz !== 1'b0 || a_done !== 1'b0 || a_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: disp=%h run=%b frz=%b done=%b wrap=%b, expected 0000 and all flags 0",
               a_disp, a_run, a_frz, a_done, a_wrap);
    end
    @(negedge clk); rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(197);
    n_chk++;
    if (a_disp !== 16'h0317 || a_run !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_count: disp=%h run=%b, expected 0317 run=1", a_disp, a_run);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (a_disp !== 16'h0000 || a_run !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: disp=%h run=%b, expected 0000 run=0", a_disp, a_run);
    end
    @(negedge clk); rst_n = 1'b1;
    ticks(3);
    n_chk++;
    if (a_disp !== 16'h0000 || a_run !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_is_idle: disp=%h run=%b, expected 0000 run=0", a_disp, a_run);
    end
  endtask

  task automatic test_start_stop;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(75);
    n_chk++;
    if (a_disp !== 16'h0115 || a_run !== 1'b1) begin
      n_fail++;
      $display("FAIL run_75: disp=%h run=%b, expected 0115 run=1", a_disp, a_run);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(10);
    n_chk++;
    if (a_disp !== 16'h0115 || a_run !== 1'b0) begin
      n_fail++;
      $display("FAIL paused: disp=%h run=%b, expected 0115 run=0", a_disp, a_run);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1);
    n_chk++;
    if (a_disp !== 16'h0116 || a_run !== 1'b1) begin
      n_fail++;
      $display("FAIL resume: disp=%h run=%b, expected 0116 run=1", a_disp, a_run);
    end
  endtask

  task automatic test_carry;
    int bad = 0;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(59);
    n_chk++;
    if (a_disp !== 16'h0059) begin
      n_fail++;
      $display("FAIL at_0059: disp=%h, expected 0059", a_disp);
    end
    ticks(1);
    n_chk++;
    if (a_disp !== 16'h0100) begin
      n_fail++;
      $display("FAIL carry_min: disp=%h, expected 0100", a_disp);
    end
    for (int i = 0; i < 539; i++) begin
      ticks(1);
      if (a_s1 > 4'd9 || a_s10 > 4'd5 || a_m1 > 4'd9 || a_m10 > 4'd9) bad++;
    end
    n_chk++;
    if (a_disp !== 16'h0959) begin
      n_fail++;
      $display("FAIL at_0959: disp=%h, expected 0959", a_disp);
    end
    ticks(1);
    n_chk++;
    if (a_disp !== 16'h1000) begin
      n_fail++;
      $display("FAIL carry_tens: disp=%h, expected 1000", a_disp);
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL bcd_range: %0d out-of-range samples, expected 0", bad);
    end
  endtask

  task automatic test_lap;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(20);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    ticks(5);
    n_chk++;
    if (a_disp !== 16'h0020 || a_frz !== 1'b1 || a_run !== 1'b1) begin
      n_fail++;
      $display("FAIL lap_frozen: disp=%h frz=%b run=%b, expected 0020 frz=1 run=1", a_disp, a_frz, a_run);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_chk++;
    if (a_disp !== 16'h0025 || a_frz !== 1'b0 || a_run !== 1'b1) begin
      n_fail++;
      $display("FAIL lap_release: disp=%h frz=%b run=%b, expected 0025 frz=0 run=1", a_disp, a_frz, a_run);
    end
    // LAP -> PAUSE via StartStop releases the display to the live value
    step(1'b0, 1'b0, 1'b0, 1'b1);
    ticks(2);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    n_chk++;
    if (a_disp !== 16'h0027 || a_frz !== 1'b0 || a_run !== 1'b0) begin
      n_fail++;
      $display("FAIL lap_to_pause: disp=%h frz=%b run=%b, expected 0027 frz=0 run=0", a_disp, a_frz, a_run);
    end
  endtask

  task automatic test_max;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(119);
    n_chk++;
    if (b_disp !== 16'h0159 || c_disp !== 16'h0159 || b_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL near_max: b=%h c=%h bwrap=%b, expected 0159 0159 0", b_disp, c_disp, b_wrap);
    end
    ticks(1);
    n_chk++;
    if (b_disp !== 16'h0000 || b_wrap !== 1'b1 || b_run !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap: disp=%h wrap=%b run=%b, expected 0000 wrap=1 run=1", b_disp, b_wrap, b_run);
    end
    n_chk++;
    if (c_disp !== 16'h0159 || c_done !== 1'b1 || c_run !== 1'b0 || c_frz !== 1'b0) begin
      n_fail++;
      $display("FAIL hold: disp=%h done=%b run=%b frz=%b, expected 0159 done=1 run=0 frz=0",
               c_disp, c_done, c_run, c_frz);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if (b_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_pulse: wrap=%b, expected 0", b_wrap);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(2);
    n_chk++;
    if (c_disp !== 16'h0159 || c_done !== 1'b1 || c_run !== 1'b0) begin
      n_fail++;
      $display("FAIL done_ignores_ss: disp=%h done=%b run=%b, expected 0159 done=1 run=0", c_disp, c_done, c_run);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(1);
    n_chk++;
    if (c_disp !== 16'h0000 || c_done !== 1'b0 || c_run !== 1'b0) begin
      n_fail++;
      $display("FAIL done_clear: disp=%h done=%b run=%b, expected 0000 done=0 run=0", c_disp, c_done, c_run);
    end
  endtask

  task automatic test_simultaneous;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(4);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    ticks(1);
    n_chk++;
    if (a_disp !== 16'h0005 || a_run !== 1'b0) begin
      n_fail++;
      $display("FAIL tick_ss_run: disp=%h run=%b, expected 0005 run=0", a_disp, a_run);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    n_chk++;
    if (a_disp !== 16'h0000 || a_run !== 1'b1) begin
      n_fail++;
      $display("FAIL tick_ss_idle: disp=%h run=%b, expected 0000 run=1", a_disp, a_run);
    end
    ticks(30);
    n_chk++;
    if (a_disp !== 16'h0030) begin
      n_fail++;
      $display("FAIL back_to_back: disp=%h, expected 0030", a_disp);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0);
    ticks(1);
    n_chk++;
    if (a_disp !== 16'h0000 || a_run !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_ss_tick: disp=%h run=%b, expected 0000 run=0", a_disp, a_run);
    end
  endtask

  initial begin
    test_reset();
    test_start_stop();
    test_carry();
    test_lap();
    test_max();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
